adder_tree_mult_pipe: RTL and testbench
=======================================

Name: adder_tree_mult_pipe

Overview:
- Parametrised successor to the AdderTree multiplier: W×W multiply, W = 2**N, built from W partial products summed by an N-level binary adder tree.
- Every tree level is registered.
- Adds a valid/ready handshake with backpressure and per-transaction signed/unsigned mode.
- Sits between operand producer and result consumer in the datapath; one result per cycle at full throughput.

Parameters:
- N, 3, log2 of operand width; W = 2**N (N=3 gives 8-bit operands).
- PW, 2*2**N, product width; derived, must not be overridden.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  operand pair present
- in_ready  out  1  block accepts operands this cycle
- in_signed  in  1  1 = two's-complement operands, 0 = unsigned
- A  in  W  multiplicand
- B  in  W  multiplier
- out_valid  out  1  P holds a valid result
- out_ready  in  1  consumer accepts P this cycle
- P  out  PW  product

Behaviour:
- Reset (clk edge with rst=1): all stage valid bits, out_valid and P are 0. in_ready is 1 in the cycle after reset.
- Reset mid-operation: all in-flight transactions are discarded, no partial outputs.
- Handshake: transfer occurs when valid && ready on the same edge.
  - Global advance = !out_valid || out_ready; in_ready = advance (combinational).
  - When advance=0, all stages hold, including data and valid bits.
  - Once out_valid=1, P and out_valid are stable until out_ready=1.
- Stage 0 (partial products):
  - Operand extension to PW bits: sign-extended if in_signed, else zero-extended; the result is A_ext.
  - pp[i] = B[i] ? (A_ext << i) : 0, for i = 0..W-1.
  - In signed mode pp[W-1] is negated (two's complement, mod 2**PW).
  - All W pp plus valid are registered.
- Stages 1..N: each stage adds adjacent pairs from the previous stage, mod 2**PW. Stage k holds W/2**k sums plus valid. Stage N holds a single sum, which drives P.
- Latency: N+1 advancing cycles from the accepting edge to out_valid=1 (4 for N=3).
- Throughput: 1 per cycle with out_ready held 1. Back-to-back transactions are never merged or dropped.
- Bubbles propagate as valid=0. A bubble's data is don't-care but must not disturb P while out_valid=0 is held.
- in_signed travels only through stage 0; it has no effect after partial-product formation.
- Simultaneous out_ready=1 and in_valid=1 with the pipe full: the head retires and the new input enters on the same edge.

Optional Feature:
- Macro: ADDER_TREE_PERF_CNT_EN.
- Defined: adds outputs perf_done (32 b) and perf_stall (32 b).
  - perf_done increments on each out_valid && out_ready.
  - perf_stall increments on each cycle with out_valid && !out_ready.
  - Both reset to 0 on rst and wrap modulo 2**32.
- Undefined: the ports and counters do not exist; the datapath is identical.

Decomposition:
- Package adder_tree_pkg holds:
  - function width_of(N) returning 2**N
  - typedef of a stage valid vector
  - localparam default N
- One sub-module, adder_tree_level:
  - Parameters: IN_CNT and PW.
  - Sums adjacent pairs into IN_CNT/2 registered outputs, with valid, enable and rst.
  - Instantiated N times by a generate loop.

Test Plan:
- Unsigned basic, N=3: A=12, B=10, in_signed=0, out_ready=1. Expect P=120, out_valid exactly 4 cycles after acceptance.
- Unsigned extremes and streaming: three back-to-back transactions (255×255, 127×2, 0×200), out_ready=1.
  - Expect P = 65025, 254, 0 on consecutive cycles.
  - in_ready remains 1 throughout.
- Signed mode:
  - 0xFF×0xFF gives P=1.
  - 0x80×0x7F gives P=0xC080 (−16256).
  - 0x80×0x80 gives P=0x4000.
  - Mix these with unsigned transactions to check that in_signed is tracked per transaction.
- Backpressure: fill the pipe with 5 transactions, then hold out_ready=0 for 6 cycles.
  - in_ready goes 0 once out_valid=1.
  - P stays stable while stalled.
  - Release out_ready: all 5 results drain in order, none lost.
- Reset mid-operation: assert rst for one cycle with 3 transactions in flight.
  - Next cycle: out_valid=0, P=0, in_ready=1.
  - None of the old results ever appear.
- Width generality: N=4, A=0xFFFF, B=0xFFFF unsigned gives P=0xFFFE0001, latency 5. With ADDER_TREE_PERF_CNT_EN defined, perf_done and perf_stall match the scoreboard counts.

Source files
------------

// File: rtl/adder_tree_pkg.sv
// -----------------------------------------------------------------------------
// adder_tree_pkg
// Shared sizing helpers and types for the pipelined adder-tree multiplier.
//   DEFAULT_N    : default log2 of the operand width (8-bit operands)
//   width_of()   : operand width for a given N (2**N)
//   level_base() : node offset of a tree level inside the flattened node vector
//   stage_vld_t  : valid bits for stages 0..DEFAULT_N
// -----------------------------------------------------------------------------
package adder_tree_pkg;

    localparam int unsigned DEFAULT_N = 3;

    // One valid bit per pipeline stage (partial-product stage plus N adder levels).
    typedef logic [DEFAULT_N:0] stage_vld_t;

    // Operand width for a tree of depth n.
    function automatic int unsigned width_of(input int unsigned n);
        return 32'(1) << n;
    endfunction

    // Index of the first node of level k when all levels are packed back to back,
    // level 0 holding w nodes and each later level half of the previous one.
    function automatic int unsigned level_base(input int unsigned w, input int unsigned k);
        return (2 * w) - ((2 * w) >> k);
    endfunction

endpackage

// File: rtl/adder_tree_level.sv
// -----------------------------------------------------------------------------
// adder_tree_level
// One registered level of the adder tree: sums adjacent pairs of IN_CNT
// PW-bit inputs into IN_CNT/2 registered outputs (mod 2**PW).
// Ports:
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset (clears valid and sums)
//   en        : global pipeline advance; level holds when low
//   in_valid  : previous level holds a valid transaction
//   in_data   : IN_CNT packed PW-bit operands, element j at [j*PW +: PW]
//   out_valid : this level holds a valid transaction
//   out_data  : IN_CNT/2 packed PW-bit sums
// -----------------------------------------------------------------------------
module adder_tree_level #(
    parameter int unsigned IN_CNT = 2,
    parameter int unsigned PW     = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic                           in_valid,
    input  logic [IN_CNT*PW-1:0]           in_data,
    output logic                           out_valid,
    output logic [(IN_CNT/2)*PW-1:0]       out_data
);

    localparam int unsigned OUT_CNT = IN_CNT / 2;

    logic                    vld_d;
    logic                    vld_q;
    logic [OUT_CNT*PW-1:0]   sum_d;
    logic [OUT_CNT*PW-1:0]   sum_q;

    // Next state: valid follows the upstream stage on advance; sums only load
    // for real transactions so bubbles never overwrite held data.
    always_comb begin
        vld_d = vld_q;
        sum_d = sum_q;
        if (en) begin
            vld_d = in_valid;
            if (in_valid) begin
                for (int j = 0; j < int'(OUT_CNT); j++) begin
                    sum_d[j*PW +: PW] = in_data[(2*j)*PW +: PW] + in_data[(2*j+1)*PW +: PW];
                end
            end
        end
    end

    // Level registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= 1'b0;
            sum_q <= '0;
        end else begin
            vld_q <= vld_d;
            sum_q <= sum_d;
        end
    end

    assign out_valid = vld_q;
    assign out_data  = sum_q;

endmodule

// File: rtl/adder_tree_mult_pipe.sv
// -----------------------------------------------------------------------------
// adder_tree_mult_pipe
// Pipelined W x W multiplier (W = 2**N): stage 0 registers W partial products,
// then N registered adder levels reduce them to the PW-bit product.
// Valid/ready handshake with a single global advance; latency N+1 advancing
// cycles, one result per cycle at full throughput.
// Ports:
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset; discards all in-flight work
//   in_valid   : operand pair present
//   in_ready   : operands accepted this cycle (combinational advance)
//   in_signed  : 1 = two's-complement operands, 0 = unsigned (per transaction)
//   A, B       : W-bit multiplicand / multiplier
//   out_valid  : P holds a valid result
//   out_ready  : consumer accepts P this cycle
//   P          : PW-bit product
// Optional (macro ADDER_TREE_PERF_CNT_EN):
//   perf_done  : count of results accepted by the consumer (wraps at 2**32)
//   perf_stall : count of cycles with a result held by backpressure
// -----------------------------------------------------------------------------
module adder_tree_mult_pipe
    import adder_tree_pkg::*;
#(
    parameter  int unsigned N  = DEFAULT_N,
    localparam int unsigned W  = width_of(N),
    localparam int unsigned PW = 2 * width_of(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_signed,
    input  logic [W-1:0]  A,
    input  logic [W-1:0]  B,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] P
`ifdef ADDER_TREE_PERF_CNT_EN
    ,
    output logic [31:0]   perf_done,
    output logic [31:0]   perf_stall
`endif
);

    // All tree nodes packed level after level: W + W/2 + ... + 1 entries.
    localparam int unsigned NODES = 2 * W - 1;

    logic                  advance_c;
    logic [PW-1:0]         a_ext_c;
    logic [W*PW-1:0]       pp_c;

    logic                  s0_vld_d;
    logic                  s0_vld_q;
    logic [W*PW-1:0]       s0_pp_d;
    logic [W*PW-1:0]       s0_pp_q;

    logic [NODES*PW-1:0]   tree;
    logic [N:0]            vld;

    // The whole pipe moves together unless a result is waiting on the consumer.
    assign advance_c = !out_valid || out_ready;
    assign in_ready  = advance_c;

    // Partial products. The multiplier's MSB carries weight -2**(W-1) in
    // signed mode, so its row is negated; the extended multiplicand makes
    // every row correct modulo 2**PW.
    always_comb begin
        a_ext_c = {{(PW-W){in_signed & A[W-1]}}, A};
        pp_c    = '0;
        for (int i = 0; i < int'(W); i++) begin
            if (B[i]) begin
                pp_c[i*PW +: PW] = a_ext_c << i;
            end
        end
        if (in_signed) begin
            pp_c[(W-1)*PW +: PW] = PW'(~pp_c[(W-1)*PW +: PW]) + PW'(1);
        end
    end

    // Stage 0 next state: data loads only for accepted transactions.
    always_comb begin
        s0_vld_d = s0_vld_q;
        s0_pp_d  = s0_pp_q;
        if (advance_c) begin
            s0_vld_d = in_valid;
            if (in_valid) begin
                s0_pp_d = pp_c;
            end
        end
    end

    // Stage 0 registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            s0_vld_q <= 1'b0;
            s0_pp_q  <= '0;
        end else begin
            s0_vld_q <= s0_vld_d;
            s0_pp_q  <= s0_pp_d;
        end
    end

    assign tree[W*PW-1:0] = s0_pp_q;
    assign vld[0]         = s0_vld_q;

    // N registered adder levels, each halving the node count.
    for (genvar k = 1; k <= int'(N); k++) begin : g_level
        localparam int unsigned IN_CNT   = W >> (k - 1);
        localparam int unsigned IN_BASE  = level_base(W, k - 1);
        localparam int unsigned OUT_BASE = level_base(W, k);

        adder_tree_level #(
            .IN_CNT (IN_CNT),
            .PW     (PW)
        ) u_level (
            .clk       (clk),
            .rst       (rst),
            .en        (advance_c),
            .in_valid  (vld[k-1]),
            .in_data   (tree[IN_BASE*PW +: IN_CNT*PW]),
            .out_valid (vld[k]),
            .out_data  (tree[OUT_BASE*PW +: (IN_CNT/2)*PW])
        );
    end

    assign out_valid = vld[N];
    assign P         = tree[(NODES-1)*PW +: PW];

`ifdef ADDER_TREE_PERF_CNT_EN
    logic [31:0] perf_done_d;
    logic [31:0] perf_done_q;
    logic [31:0] perf_stall_d;
    logic [31:0] perf_stall_q;

    // Completed handshakes and backpressure cycles; both wrap naturally.
    always_comb begin
        perf_done_d  = perf_done_q;
        perf_stall_d = perf_stall_q;
        if (out_valid && out_ready) begin
            perf_done_d = perf_done_q + 32'd1;
        end
        if (out_valid && !out_ready) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_done_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_done_q  <= perf_done_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_done  = perf_done_q;
    assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_adder_tree_mult_pipe.sv
// -----------------------------------------------------------------------------
// tb_adder_tree_mult_pipe
// Bench for the pipelined adder-tree multiplier: an N=3 instance driven by
// directed and random traffic against a product scoreboard, and an N=4
// instance for width generality. Perf counters are compared when
// ADDER_TREE_PERF_CNT_EN is defined.
// -----------------------------------------------------------------------------
module tb_adder_tree_mult_pipe;

    logic        clk;
    logic        rst;

    // N = 3 instance
    logic        in_valid, in_ready, in_signed, out_valid, out_ready;
    logic [7:0]  A, B;
    logic [15:0] P;

    // N = 4 instance
    logic        in_valid4, in_ready4, in_signed4, out_valid4, out_ready4;
    logic [15:0] a4, b4;
    logic [31:0] p4;

`ifdef ADDER_TREE_PERF_CNT_EN
    logic [31:0] perf_done, perf_stall, perf_done4, perf_stall4;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    adder_tree_mult_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_signed (in_signed),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .P         (P)
`ifdef ADDER_TREE_PERF_CNT_EN
        ,
        .perf_done (perf_done),
        .perf_stall(perf_stall)
`endif
    );

    adder_tree_mult_pipe #(.N(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .in_signed (in_signed4),
        .A         (a4),
        .B         (b4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .P         (p4)
`ifdef ADDER_TREE_PERF_CNT_EN
        ,
        .perf_done (perf_done4),
        .perf_stall(perf_stall4)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference products: plain integer multiplication, reduced to the product width.
    function automatic logic [15:0] model8(input logic [7:0] a, input logic [7:0] b, input logic s);
        if (s) return 16'($signed({{8{a[7]}}, a}) * $signed({{8{b[7]}}, b}));
        return {8'b0, a} * {8'b0, b};
    endfunction

    function automatic logic [31:0] model16(input logic [15:0] a, input logic [15:0] b, input logic s);
        if (s) return 32'($signed({{16{a[15]}}, a}) * $signed({{16{b[15]}}, b}));
        return {16'b0, a} * {16'b0, b};
    endfunction

    // Scoreboard for the N=3 instance, sampled on the falling edge so every
    // observed handshake is the one the next rising edge will perform.
    logic [15:0] exp_q[$];
    int          n_done  = 0;
    int          n_stall = 0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_p;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            n_done     = 0;
            n_stall    = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_out_valid", 64'(out_valid), 64'd1);
                check("hold_p", 64'(P), 64'(prev_p));
            end
            check("in_ready_rule", 64'(in_ready), 64'(!out_valid || out_ready));
            if (in_valid && in_ready) exp_q.push_back(model8(A, B, in_signed));
            if (out_valid && out_ready) begin
                n_done++;
                if (exp_q.size() == 0) check("unexpected_out", 64'(P), 64'hDEAD_0000_0000);
                else check("sb_p", 64'(P), 64'(exp_q.pop_front()));
            end
            if (out_valid && !out_ready) n_stall++;
            prev_stall = out_valid && !out_ready;
            prev_p     = P;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic s, output int waits);
        A = a; B = b; in_signed = s; in_valid = 1'b1; waits = 0;
        @(negedge clk);
        while (!in_ready && waits < 200) begin
            waits++;
            @(negedge clk);
        end
        if (!in_ready) check("send_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out();
        int g = 0;
        @(negedge clk);
        while (!out_valid && g < 20) begin
            g++;
            @(negedge clk);
        end
        if (!out_valid) check("wait_out_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        int g = 0;
        while ((exp_q.size() != 0 || out_valid) && g < 300) begin
            @(negedge clk);
            g++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    int n4_sent = 0;

    // Single isolated N=4 transaction: latency 5 and product value.
    task automatic send4(input logic [15:0] a, input logic [15:0] b, input logic s);
        a4 = a; b4 = b; in_signed4 = s; in_valid4 = 1'b1;
        @(negedge clk);
        check("n4_in_ready", 64'(in_ready4), 64'd1);
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        n4_sent++;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (i < 5) check("n4_lat_idle", 64'(out_valid4), 64'd0);
            else begin
                check("n4_lat_valid", 64'(out_valid4), 64'd1);
                check("n4_p", 64'(p4), 64'(model16(a, b, s)));
            end
        end
        @(posedge clk); #1;
    endtask

    logic prod_done;

    initial begin
        int w;
        rst = 1'b1; in_valid = 1'b0; in_signed = 1'b0; A = '0; B = '0; out_ready = 1'b1;
        in_valid4 = 1'b0; in_signed4 = 1'b0; a4 = '0; b4 = '0; out_ready4 = 1'b1;
        prod_done = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_p", 64'(P), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid4", 64'(out_valid4), 64'd0);
        @(posedge clk); #1;

        // Unsigned basic, latency 4
        send(8'd12, 8'd10, 1'b0, w);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i < 4) check("basic_lat_idle", 64'(out_valid), 64'd0);
            else begin
                check("basic_lat_valid", 64'(out_valid), 64'd1);
                check("basic_p", 64'(P), 64'd120);
            end
        end
        @(posedge clk); #1;

        // Streaming extremes on consecutive cycles
        send(8'd255, 8'd255, 1'b0, w); check("stream_wait0", 64'(w), 64'd0);
        send(8'd127, 8'd2,   1'b0, w); check("stream_wait1", 64'(w), 64'd0);
        send(8'd0,   8'd200, 1'b0, w); check("stream_wait2", 64'(w), 64'd0);
        wait_out();
        check("stream_p0", 64'(P), 64'd65025);
        @(negedge clk);
        check("stream_v1", 64'(out_valid), 64'd1);
        check("stream_p1", 64'(P), 64'd254);
        @(negedge clk);
        check("stream_v2", 64'(out_valid), 64'd1);
        check("stream_p2", 64'(P), 64'd0);
        @(posedge clk); #1;
        drain();

        // Signed / unsigned mix, tracked per transaction
        send(8'hFF, 8'hFF, 1'b1, w);
        send(8'hFF, 8'hFF, 1'b0, w);
        send(8'h80, 8'h7F, 1'b1, w);
        send(8'h80, 8'h7F, 1'b0, w);
        send(8'h80, 8'h80, 1'b1, w);
        send(8'h0C, 8'hF6, 1'b1, w);
        drain();

        // Backpressure: fill, stall 6 cycles, then drain in order
        out_ready = 1'b0;
        send(8'd3,  8'd7,  1'b0, w);
        send(8'hF0, 8'd9,  1'b1, w);
        send(8'd100, 8'd100, 1'b0, w);
        send(8'h81, 8'h02, 1'b1, w);
        fork
            send(8'd17, 8'd19, 1'b0, w);
            begin
                repeat (6) begin
                    @(negedge clk);
                    check("bp_in_ready", 64'(in_ready), 64'd0);
                    check("bp_out_valid", 64'(out_valid), 64'd1);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with three transactions in flight
        send(8'd11, 8'd13, 1'b0, w);
        send(8'd21, 8'd23, 1'b1, w);
        send(8'd31, 8'd37, 1'b0, w);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_p", 64'(P), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        repeat (8) begin
            @(negedge clk);
            check("midrst_no_old", 64'(out_valid), 64'd0);
        end
        @(posedge clk); #1;

        // Random traffic with random backpressure
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk); #1;
                    end
                    send(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), w);
                end
                prod_done = 1'b1;
            end
            begin
                while (!prod_done) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();

`ifdef ADDER_TREE_PERF_CNT_EN
        @(negedge clk);
        check("perf_done", 64'(perf_done), 64'(n_done));
        check("perf_stall", 64'(perf_stall), 64'(n_stall));
        @(posedge clk); #1;
`endif

        // Width generality, N = 4
        send4(16'hFFFF, 16'hFFFF, 1'b0);
        check("n4_ffff_p", 64'(p4), 64'hFFFE_0001);
        for (int i = 0; i < 4; i++) begin
            send4(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
        end

`ifdef ADDER_TREE_PERF_CNT_EN
        @(negedge clk);
        check("perf_done4", 64'(perf_done4), 64'(n4_sent));
        check("perf_stall4", 64'(perf_stall4), 64'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks so far", n_pass, n_checks);
        $fatal(1);
    end

endmodule
